// File: rtl/video_stream_pkg.sv
// Shared definitions for the video-in streaming stages:
// pixel layout, clipper FSM states and clip-window helpers.
package video_stream_pkg;

    // RGB565 field positions within a 16-bit pixel
    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

    typedef enum logic {
        WAIT_SOP = 1'b0,
        ACTIVE   = 1'b1
    } clip_state_t;

    // First kept column/line given what is dropped on the low side
    function automatic int first_kept(input int drop_lo);
        return drop_lo;
    endfunction

    // Last kept column/line given the size and what is dropped on the high side
    function automatic int last_kept(input int size, input int drop_hi);
        return size - drop_hi - 1;
    endfunction

    // A window is usable only if at least one column/line survives
    function automatic bit window_ok(input int size, input int lo, input int hi);
        return (lo >= 0) && (hi >= 0) && (lo + hi < size);
    endfunction

endpackage

// File: rtl/video_in_clipper_if.sv
// Avalon-ST video beat bundle with its handshake.
// master drives the beat, slave returns ready.
interface video_in_clipper_if #(
    parameter int DW = 15,
    parameter int EW = 0
);
    logic [DW:0] data;
    logic        startofpacket;
    logic        endofpacket;
    logic [EW:0] empty;
    logic        valid;
    logic        ready;

    modport master (
        output data,
        output startofpacket,
        output endofpacket,
        output empty,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  startofpacket,
        input  endofpacket,
        input  empty,
        input  valid,
        output ready
    );
endinterface

// File: rtl/video_stream_out_reg.sv
// One-deep registered output stage for video-in streams.
// Upstream may advance whenever the register is empty or being drained.
module video_stream_out_reg #(
    parameter int DW = 15,
    parameter int EW = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DW:0]         data_i,
    input  logic                sop_i,
    input  logic                eop_i,
    input  logic                valid_i,
    output logic                in_ready_o,
    video_in_clipper_if.master  stream_out
);

    logic [DW:0] data_q;
    logic        sop_q;
    logic        eop_q;
    logic        valid_q;

    // Register may be overwritten when it holds nothing or is being taken
    always_comb begin
        in_ready_o = stream_out.ready | ~valid_q;
    end

    // Load a new beat whenever the stage can advance, otherwise hold
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (in_ready_o) begin
            data_q  <= data_i;
            sop_q   <= sop_i;
            eop_q   <= eop_i;
            valid_q <= valid_i;
        end
    end

    assign stream_out.data          = data_q;
    assign stream_out.startofpacket = sop_q;
    assign stream_out.endofpacket   = eop_q;
    assign stream_out.empty         = '0;
    assign stream_out.valid         = valid_q;

endmodule

// File: rtl/video_in_clipper.sv
// Crops each incoming video frame to a fixed window and
// regenerates start/end of packet for the cropped frame.
module video_in_clipper
    import video_stream_pkg::*;
#(
    parameter int DW          = 15,
    parameter int EW          = 0,
    parameter int WIDTH_IN    = 720,
    parameter int HEIGHT_IN   = 244,
    parameter int DROP_LEFT   = 0,
    parameter int DROP_RIGHT  = 0,
    parameter int DROP_TOP    = 0,
    parameter int DROP_BOTTOM = 0
) (
    input  logic               clk,
    input  logic               reset,
    video_in_clipper_if.slave  stream_in,
    video_in_clipper_if.master stream_out
);

    localparam int XW = (WIDTH_IN > 1) ? $clog2(WIDTH_IN) : 1;
    localparam int YW = $clog2(HEIGHT_IN + 1);

    localparam logic [XW-1:0] X_FIRST = XW'(first_kept(DROP_LEFT));
    localparam logic [XW-1:0] X_LAST  = XW'(last_kept(WIDTH_IN, DROP_RIGHT));
    localparam logic [XW-1:0] X_SPAN  = X_LAST - X_FIRST;
    localparam logic [XW-1:0] X_MAX   = XW'(WIDTH_IN - 1);

    localparam logic [YW-1:0] Y_FIRST = YW'(first_kept(DROP_TOP));
    localparam logic [YW-1:0] Y_LAST  = YW'(last_kept(HEIGHT_IN, DROP_BOTTOM));
    localparam logic [YW-1:0] Y_SPAN  = Y_LAST - Y_FIRST;
    localparam logic [YW-1:0] Y_SAT   = YW'(HEIGHT_IN);

    generate
        if (!window_ok(WIDTH_IN, DROP_LEFT, DROP_RIGHT)) begin : g_bad_w
            $error("video_in_clipper: horizontal crop removes every column");
        end
        if (!window_ok(HEIGHT_IN, DROP_TOP, DROP_BOTTOM)) begin : g_bad_h
            $error("video_in_clipper: vertical crop removes every line");
        end
    endgenerate

    clip_state_t   state_q;
    clip_state_t   state_d;
    logic [XW-1:0] x_q;
    logic [XW-1:0] x_d;
    logic [YW-1:0] y_q;
    logic [YW-1:0] y_d;

    logic          in_ready;
    logic          accept;
    logic          eval_en;
    logic [XW-1:0] ex;
    logic [YW-1:0] ey;
    logic [XW-1:0] x_off;
    logic [YW-1:0] y_off;
    logic          keep;
    logic          sop_d;
    logic          eop_d;

    // The empty field carries nothing for pixel streams
    logic unused_empty;
    assign unused_empty = ^stream_in.empty;

    assign stream_in.ready = in_ready;

    // Place the accepted beat in the frame and decide whether it survives
    always_comb begin
        accept  = stream_in.valid & in_ready;
        eval_en = accept & (stream_in.startofpacket | (state_q == ACTIVE));
        ex      = stream_in.startofpacket ? '0 : x_q;
        ey      = stream_in.startofpacket ? '0 : y_q;
        // Offset compare: values below the first kept index wrap high
        x_off   = ex - X_FIRST;
        y_off   = ey - Y_FIRST;
        keep    = eval_en & (x_off <= X_SPAN) & (y_off <= Y_SPAN);
        sop_d   = keep & (ex == X_FIRST) & (ey == Y_FIRST);
        eop_d   = keep & (((ex == X_LAST) & (ey == Y_LAST))
                          | stream_in.endofpacket);
    end

    // Advance the raster position and frame state on each evaluated beat
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        if (eval_en) begin
            if (stream_in.endofpacket) begin
                state_d = WAIT_SOP;
                x_d     = '0;
                y_d     = '0;
            end else begin
                state_d = ACTIVE;
                if (ex == X_MAX) begin
                    x_d = '0;
                    y_d = (ey == Y_SAT) ? Y_SAT : ey + 1'b1;
                end else begin
                    x_d = ex + 1'b1;
                    y_d = ey;
                end
            end
        end
    end

    // Frame state and raster counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_SOP;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    video_stream_out_reg #(
        .DW (DW),
        .EW (EW)
    ) u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .data_i     (stream_in.data),
        .sop_i      (sop_d),
        .eop_i      (eop_d),
        .valid_i    (keep),
        .in_ready_o (in_ready),
        .stream_out (stream_out)
    );

endmodule

// File: tb/tb_video_in_clipper.sv
// Directed bench for video_in_clipper on an 8x6 frame
// cropped to columns 1..5, lines 1..4.
module tb_video_in_clipper;

    typedef struct {
        logic [15:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    video_in_clipper_if #(.DW(15), .EW(0)) in_if ();
    video_in_clipper_if #(.DW(15), .EW(0)) out_if ();

    video_in_clipper #(
        .DW          (15),
        .EW          (0),
        .WIDTH_IN    (8),
        .HEIGHT_IN   (6),
        .DROP_LEFT   (1),
        .DROP_RIGHT  (2),
        .DROP_TOP    (1),
        .DROP_BOTTOM (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stream_in  (in_if),
        .stream_out (out_if)
    );

    int    checks = 0;
    int    failures = 0;
    int    timeouts = 0;
    int    rmode = 0;
    bit    lat_chk = 0;
    bit    watch_rdy = 0;
    int    hold_err = 0;
    int    bp_err = 0;
    int    rdy_low = 0;
    int    stalls = 0;
    bit    prev_stall = 0;
    beat_t prev_b;
    beat_t cap[$];

    beat_t e_full[$];
    beat_t e_short[$];
    beat_t e_restart[$];
    beat_t e_pre_rst[$];

    function automatic beat_t mkb(input logic [15:0] d, input logic s, input logic e);
        beat_t b;
        b.data = d;
        b.sop  = s;
        b.eop  = e;
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream monitor: captures transfers, watches backpressure rules
    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (out_if.valid !== 1'b1 || out_if.data !== prev_b.data
                || out_if.startofpacket !== prev_b.sop || out_if.endofpacket !== prev_b.eop))
                hold_err <= hold_err + 1;
            if (out_if.valid && !out_if.ready && in_if.ready)
                bp_err <= bp_err + 1;
            if (out_if.valid && !out_if.ready)
                stalls <= stalls + 1;
            if (watch_rdy && !in_if.ready)
                rdy_low <= rdy_low + 1;
            if (out_if.valid && out_if.ready)
                cap.push_back(mkb(out_if.data, out_if.startofpacket, out_if.endofpacket));
            prev_stall <= out_if.valid && !out_if.ready;
            prev_b <= mkb(out_if.data, out_if.startofpacket, out_if.endofpacket);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rmode)
            1:       out_if.ready = ~out_if.ready;
            2:       out_if.ready = 1'b0;
            default: out_if.ready = 1'b1;
        endcase
    endtask

    task automatic send_beat(input int d, input bit s, input bit e);
        bit acc;
        acc = 1'b0;
        in_if.valid = 1'b1;
        in_if.data = d[15:0];
        in_if.startofpacket = s;
        in_if.endofpacket = e;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = in_if.ready;
            tick();
        end
        if (!acc) begin
            timeouts++;
            $display("FAIL accept_timeout: beat %0d not accepted within 20 cycles", d);
        end
        if (lat_chk && d == 9) begin
            chk("latency_valid", 32'(out_if.valid), 32'd1);
            chk("latency_data", 32'(out_if.data), 32'd9);
            chk("latency_sop", 32'(out_if.startofpacket), 32'd1);
        end
    endtask

    task automatic send_frame(input int base, input int n, input int sop_at, input int eop_at);
        for (int i = 0; i < n; i++)
            send_beat(base + i, i == sop_at, i == eop_at);
    endtask

    task automatic idle(input int n);
        in_if.valid = 1'b0;
        in_if.startofpacket = 1'b0;
        in_if.endofpacket = 1'b0;
        rmode = 0;
        repeat (n) tick();
    endtask

    task automatic check_stream(input string name, input beat_t exp[$]);
        int n;
        chk($sformatf("%s_count", name), 32'(cap.size()), 32'(exp.size()));
        n = (cap.size() < exp.size()) ? cap.size() : exp.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_beat%0d", name, i),
                {14'd0, cap[i].data, cap[i].sop, cap[i].eop},
                {14'd0, exp[i].data, exp[i].sop, exp[i].eop});
        cap.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        automatic int fidx[20] = '{9, 10, 11, 12, 13, 17, 18, 19, 20, 21,
                                   25, 26, 27, 28, 29, 33, 34, 35, 36, 37};
        automatic int sidx[9] = '{9, 10, 11, 12, 13, 17, 18, 19, 20};

        for (int i = 0; i < 20; i++)
            e_full.push_back(mkb(16'(fidx[i]), i == 0, i == 19));
        for (int i = 0; i < 9; i++)
            e_short.push_back(mkb(16'(sidx[i]), i == 0, i == 8));
        for (int i = 0; i < 15; i++)
            e_restart.push_back(mkb(16'(fidx[i]), i == 0, 1'b0));
        for (int i = 0; i < 20; i++)
            e_restart.push_back(mkb(16'(fidx[i] + 30), i == 0, i == 19));
        e_pre_rst.push_back(mkb(16'd9, 1'b1, 1'b0));
        e_pre_rst.push_back(mkb(16'd10, 1'b0, 1'b0));

        in_if.data = '0;
        in_if.startofpacket = 1'b0;
        in_if.endofpacket = 1'b0;
        in_if.empty = '0;
        in_if.valid = 1'b0;
        out_if.ready = 1'b1;

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_valid", 32'(out_if.valid), 32'd0);
        chk("rst_data", 32'(out_if.data), 32'd0);
        chk("rst_sop", 32'(out_if.startofpacket), 32'd0);
        chk("rst_eop", 32'(out_if.endofpacket), 32'd0);
        chk("rst_empty", 32'(out_if.empty), 32'd0);
        chk("rst_in_ready", 32'(in_if.ready), 32'd1);

        // 1: full frame, no backpressure
        lat_chk = 1;
        send_frame(0, 48, 0, 47);
        lat_chk = 0;
        idle(4);
        check_stream("full", e_full);

        // 2: downstream ready toggling every cycle
        rmode = 1;
        send_frame(0, 48, 0, 47);
        idle(6);
        check_stream("toggle", e_full);
        chk("toggle_stalls_seen", 32'(stalls > 0), 32'd1);
        chk("toggle_bp_ready", 32'(bp_err), 32'd0);
        chk("toggle_hold", 32'(hold_err), 32'd0);

        // 3: garbage before the first sop is swallowed
        watch_rdy = 1;
        for (int i = 0; i < 5; i++)
            send_beat(100 + i, 1'b0, i == 2);
        idle(3);
        watch_rdy = 0;
        chk("nosop_ready_low", 32'(rdy_low), 32'd0);
        chk("nosop_outputs", 32'(cap.size()), 32'd0);
        send_frame(0, 48, 0, 47);
        idle(4);
        check_stream("after_nosop", e_full);

        // 4: short frame ends early, next frame is unaffected
        send_frame(0, 21, 0, 20);
        idle(3);
        check_stream("short", e_short);
        send_frame(0, 48, 0, 47);
        idle(4);
        check_stream("after_short", e_full);

        // 5: sop reasserted mid-frame restarts the raster
        send_frame(0, 30, 0, -1);
        send_frame(30, 48, 0, 47);
        idle(4);
        check_stream("restart", e_restart);

        // 6: reset with a stalled output pending
        send_frame(0, 11, 0, -1);
        rmode = 2;
        send_beat(11, 1'b0, 1'b0);
        in_if.valid = 1'b0;
        chk("pre_rst_pending", 32'(out_if.valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", 32'(out_if.valid), 32'd0);
        chk("mid_rst_data", 32'(out_if.data), 32'd0);
        chk("mid_rst_sop", 32'(out_if.startofpacket), 32'd0);
        chk("mid_rst_eop", 32'(out_if.endofpacket), 32'd0);
        chk("mid_rst_in_ready", 32'(in_if.ready), 32'd1);
        rmode = 0;
        for (int i = 12; i < 21; i++)
            send_beat(i, 1'b0, 1'b0);
        idle(3);
        check_stream("pre_rst", e_pre_rst);
        send_frame(0, 48, 0, 47);
        idle(4);
        check_stream("after_rst", e_full);

        chk("overall_hold", 32'(hold_err), 32'd0);
        chk("overall_bp_ready", 32'(bp_err), 32'd0);
        chk("no_timeouts", 32'(timeouts), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
